// File: rtl/hexa_display_seq.sv
// hexa_display_seq: binary 0..99 to two digit codes via repeated subtract-10, plus a chasing-segment animation.
module hexa_display_seq #(
  parameter int VOLTAS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] valor,
  input  logic       carrega,
  input  logic       anima,
  output logic [4:0] hexa0,
  output logic [4:0] hexa1,
  output logic       ocupado,
  output logic       pronto
);
  typedef enum logic [1:0] {IDLE, CONV, SHOW, ANIM} state_t;
  state_t     state;
  logic [4:0] d1, d0;
  logic [6:0] resto;
  logic [3:0] dezena;
  logic       erro;
  logic [2:0] passo;
  logic [3:0] volta;
  assign hexa1   = state == ANIM ? 5'h10 + {2'b00, passo} : d1;
  assign hexa0   = state == ANIM ? 5'h10 + {2'b00, passo} : d0;
  assign ocupado = state == CONV || state == ANIM;
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      d1     <= 5'h16;
      d0     <= 5'h16;
      resto  <= '0;
      dezena <= '0;
      erro   <= 1'b0;
      passo  <= '0;
      volta  <= '0;
      pronto <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (state == CONV) begin
        if (erro || resto < 7'd10) begin
          d1     <= erro ? 5'h16 : {1'b0, dezena};
          d0     <= erro ? 5'h16 : {1'b0, resto[3:0]};
          pronto <= 1'b1;
          state  <= SHOW;
        end else begin
          resto  <= resto - 7'd10;
          dezena <= dezena + 4'd1;
        end
      end else if (carrega) begin
        resto  <= valor;
        dezena <= '0;
        erro   <= valor > 7'd99;
        state  <= CONV;
      end else if (state != ANIM && anima) begin
        passo <= '0;
        volta <= '0;
        state <= ANIM;
      end else if (state == ANIM && tick) begin
        if (passo < 3'd5) passo <= passo + 3'd1;
        else begin
          passo <= '0;
          if (volta == 4'(VOLTAS - 1)) state <= SHOW;
          else volta <= volta + 4'd1;
        end
      end
    end
  end
endmodule
